// File: rtl/vector_sequencer.sv
// On-chip test-vector sequencer: applies stored stimulus to a combinational datapath,
// compares each response against its stored expected value and counts mismatches.
module vector_sequencer #(
  parameter int unsigned IN_W   = 2,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_en,
  input  logic [$clog2(DEPTH)-1:0]     load_addr,
  input  logic [IN_W+OUT_W-1:0]        load_data,
  input  logic                         clear,
  input  logic                         start,
  output logic [IN_W-1:0]              dut_in,
  input  logic [OUT_W-1:0]             dut_out,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   vec_idx,
  output logic [$clog2(DEPTH+1)-1:0]   err_cnt,
  output logic                         fail,
  output logic                         err_pulse,
  output logic [$clog2(DEPTH)-1:0]     err_idx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [IN_W-1:0]   r_dut_in, w_dut_in_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [CW-1:0]     r_vec_idx, w_vec_idx_nxt;
  logic [CW-1:0]     r_err_cnt, w_err_cnt_nxt;
  logic              r_fail, w_fail_nxt;
  logic              r_err_pulse, w_err_pulse_nxt;
  logic [AW-1:0]     r_err_idx, w_err_idx_nxt;
  logic [AW-1:0]     r_idx, w_idx_nxt;
  logic [SW-1:0]     r_settle, w_settle_nxt;

  logic [IN_W-1:0]   r_stim [DEPTH];
  logic [OUT_W-1:0]  r_exp  [DEPTH];
  logic [DEPTH-1:0]  r_valid;

  logic [AW-1:0]     w_idx_inc;
  logic              w_last;
  logic              w_mis;

  // Table payload has no reset; only the valid bits define table contents.
  always_ff @(posedge clk) begin
    if (load_en && !clear && !r_busy) begin
      r_stim[load_addr] <= load_data[IN_W+OUT_W-1:OUT_W];
      r_exp[load_addr]  <= load_data[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (!r_busy) begin
      if (clear)        r_valid <= '0;
      else if (load_en) r_valid[load_addr] <= 1'b1;
    end
  end

  assign w_idx_inc = r_idx + AW'(1);
  assign w_last    = (r_idx == AW'(DEPTH - 1));
  assign w_mis     = (dut_out != r_exp[r_idx]);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_dut_in_nxt    = r_dut_in;
    w_vec_idx_nxt   = r_vec_idx;
    w_err_cnt_nxt   = r_err_cnt;
    w_fail_nxt      = r_fail;
    w_err_pulse_nxt = 1'b0;
    w_err_idx_nxt   = r_err_idx;
    w_idx_nxt       = r_idx;
    w_settle_nxt    = r_settle;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_vec_idx_nxt = '0;
          w_err_cnt_nxt = '0;
          w_fail_nxt    = 1'b0;
          w_err_idx_nxt = '0;
          w_idx_nxt     = '0;
          if (r_valid[0]) begin
            w_state_nxt  = S_RUN;
            w_dut_in_nxt = r_stim[0];
            w_settle_nxt = SW'(SETTLE - 1);
          end else begin
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (r_settle == '0) begin
          if (w_mis) begin
            w_err_cnt_nxt   = r_err_cnt + CW'(1);
            w_err_idx_nxt   = r_idx;
            w_err_pulse_nxt = 1'b1;
            w_fail_nxt      = 1'b1;
          end
          w_vec_idx_nxt = r_vec_idx + CW'(1);
          if (w_last || !r_valid[w_idx_inc]) begin
            w_state_nxt  = S_DONE;
          end else begin
            w_idx_nxt    = w_idx_inc;
            w_dut_in_nxt = r_stim[w_idx_inc];
            w_settle_nxt = SW'(SETTLE - 1);
          end
        end else begin
          w_settle_nxt = r_settle - SW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dut_in    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_vec_idx   <= '0;
      r_err_cnt   <= '0;
      r_fail      <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_idx   <= '0;
      r_idx       <= '0;
      r_settle    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dut_in    <= w_dut_in_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_vec_idx   <= w_vec_idx_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_fail      <= w_fail_nxt;
      r_err_pulse <= w_err_pulse_nxt;
      r_err_idx   <= w_err_idx_nxt;
      r_idx       <= w_idx_nxt;
      r_settle    <= w_settle_nxt;
    end
  end

  assign dut_in    = r_dut_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign vec_idx   = r_vec_idx;
  assign err_cnt   = r_err_cnt;
  assign fail      = r_fail;
  assign err_pulse = r_err_pulse;
  assign err_idx   = r_err_idx;

endmodule
